// File: rtl/acq_sequencer.sv
// Acquisition sequencer for the scope capture path.
// Sequences pre-fill, arm, trigger detect, post-fill and display handoff of a ring-buffer
// capture, with AUTO/NORMAL/SINGLE/STOP run modes, auto-trigger timeout and re-arm holdoff.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   mode        00 AUTO, 01 NORMAL, 10 SINGLE, 11 STOP
//   single_arm  pulse, starts one capture in SINGLE mode
//   sample_en   sample valid strobe
//   sample      ADC sample
//   level       trigger level (unsigned)
//   slope       0 rising, 1 falling
//   read        consumer takes the frame
//   wr_en       buffer write strobe
//   wr_addr     buffer write address
//   wr_data     buffer write data
//   start_addr  address of the oldest sample of the captured window
//   ready       complete frame available
//   auto_trig   last frame was forced by the AUTO timeout
//   busy        sequencer is neither idle nor holding a finished frame
module acq_sequencer #(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned PRE_TRIG     = 64,
  parameter int unsigned AUTO_TIMEOUT = 4096,
  parameter int unsigned HOLDOFF      = 16,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              single_arm,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  input  logic              read,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [AW-1:0]     start_addr,
  output logic              ready,
  output logic              auto_trig,
  output logic              busy
);

  localparam logic [1:0] ModeAuto   = 2'b00;
  localparam logic [1:0] ModeSingle = 2'b10;
  localparam logic [1:0] ModeStop   = 2'b11;

  localparam int unsigned PostN = DEPTH - PRE_TRIG;

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StArmed,
    StPost,
    StDone,
    StHold
  } state_t;

  state_t            state_q;
  logic [1:0]        run_mode_q;   // mode latched at IDLE/HOLD exit
  logic [31:0]       cnt_q;        // PREFILL/POST/HOLD strobe counter
  logic [31:0]       to_cnt_q;     // ARMED strobes without trigger
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid_q;

  logic [AW-1:0] next_addr;
  logic          rise_hit;
  logic          fall_hit;
  logic          trig_hit;
  logic          timeout_hit;
  logic          write_state;

  always_comb begin
    // wr_addr shows the address of the write in flight; it advances the cycle after.
    next_addr   = wr_en ? wr_addr + AW'(1) : wr_addr;
    rise_hit    = prev_valid_q && (prev_q < level) && (sample >= level);
    fall_hit    = prev_valid_q && (prev_q > level) && (sample <= level);
    trig_hit    = slope ? fall_hit : rise_hit;
    // Timeout follows the live mode, not the latched one.
    timeout_hit = (mode == ModeAuto) && (to_cnt_q == AUTO_TIMEOUT - 1);
    write_state = (state_q == StPrefill) || (state_q == StArmed) || (state_q == StPost);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      run_mode_q   <= 2'b00;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      start_addr   <= '0;
      ready        <= 1'b0;
      auto_trig    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      wr_addr <= next_addr;
      wr_en   <= 1'b0;
      if (mode == ModeStop) begin
        // Abort: buffer pointers are kept, everything else returns to idle.
        state_q      <= StIdle;
        ready        <= 1'b0;
        busy         <= 1'b0;
        cnt_q        <= '0;
        to_cnt_q     <= '0;
        prev_valid_q <= 1'b0;
      end else begin
        if (sample_en && write_state) begin
          wr_en        <= 1'b1;
          wr_data      <= sample;
          prev_q       <= sample;
          prev_valid_q <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            if ((mode != ModeSingle) || single_arm) begin
              state_q    <= StPrefill;
              run_mode_q <= mode;
              busy       <= 1'b1;
              cnt_q      <= '0;
            end
          end
          StPrefill: begin
            if (sample_en) begin
              if (cnt_q == PRE_TRIG - 1) begin
                state_q  <= StArmed;
                cnt_q    <= '0;
                to_cnt_q <= '0;
              end else begin
                cnt_q <= cnt_q + 32'd1;
              end
            end
          end
          StArmed: begin
            if (sample_en && (trig_hit || timeout_hit)) begin
              start_addr <= next_addr - AW'(PRE_TRIG);
              auto_trig  <= !trig_hit;  // a real trigger wins over the timeout
              // The trigger sample is the first post sample.
              if (PostN == 1) begin
                state_q <= StDone;
                ready   <= 1'b1;
                busy    <= 1'b0;
                cnt_q   <= '0;
              end else begin
                state_q <= StPost;
                cnt_q   <= 32'd1;
              end
            end else if (sample_en && (to_cnt_q != AUTO_TIMEOUT - 1)) begin
              // Saturate so a later switch to AUTO fires on the next strobe.
              to_cnt_q <= to_cnt_q + 32'd1;
            end
          end
          StPost: begin
            if (sample_en) begin
              if (cnt_q == PostN - 1) begin
                state_q <= StDone;
                ready   <= 1'b1;
                busy    <= 1'b0;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 32'd1;
              end
            end
          end
          StDone: begin
            if (read && ready) begin
              ready <= 1'b0;
              cnt_q <= '0;
              if (run_mode_q == ModeSingle) begin
                state_q      <= StIdle;
                prev_valid_q <= 1'b0;
              end else if (HOLDOFF > 0) begin
                state_q      <= StHold;
                busy         <= 1'b1;
                prev_valid_q <= 1'b0;
              end else begin
                state_q <= StPrefill;
                busy    <= 1'b1;
              end
            end
          end
          StHold: begin
            if (sample_en) begin
              if (cnt_q == HOLDOFF - 1) begin
                state_q    <= StPrefill;
                run_mode_q <= mode;
                cnt_q      <= '0;
              end else begin
                cnt_q <= cnt_q + 32'd1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
module tb_acq_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        single_arm;
  logic        sample_en;
  logic [11:0] sample;
  logic [11:0] level;
  logic        slope;
  logic        read;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [11:0] wr_data;
  logic [7:0]  start_addr;
  logic        ready;
  logic        auto_trig;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_addr;
  logic [7:0] trig_addr;
  logic [7:0] exp_start;

  always #5 clk = ~clk;

  acq_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .single_arm (single_arm),
    .sample_en  (sample_en),
    .sample     (sample),
    .level      (level),
    .slope      (slope),
    .read       (read),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start_addr (start_addr),
    .ready      (ready),
    .auto_trig  (auto_trig),
    .busy       (busy)
  );

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One strobe followed by one quiet cycle; checks the resulting write (or its absence).
  task automatic strobe(input logic [11:0] s, input logic exp_wr);
    sample_en = 1'b1;
    sample    = s;
    cycle();
    sample_en = 1'b0;
    checks++;
    if (wr_en !== exp_wr) begin
      errors++;
      $display("FAIL strobe_wr_en: got %b want %b (sample %h)", wr_en, exp_wr, s);
    end
    if (exp_wr) begin
      checks++;
      if (wr_addr !== exp_addr || wr_data !== s) begin
        errors++;
        $display("FAIL strobe_write: addr %0d data %h want addr %0d data %h",
                 wr_addr, wr_data, exp_addr, s);
      end
      exp_addr = exp_addr + 8'd1;
    end
    cycle();
  endtask

  task automatic pulse_read();
    read = 1'b1;
    cycle();
    read = 1'b0;
  endtask

  task automatic pulse_arm();
    single_arm = 1'b1;
    cycle();
    single_arm = 1'b0;
  endtask

  task automatic stop_now();
    mode = 2'b11;
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0; mode = 2'b11; single_arm = 1'b0; sample_en = 1'b0; sample = '0;
    level = 12'h800; slope = 1'b0; read = 1'b0;
    cycle();
    cycle();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 8'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 12'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (start_addr !== 8'd0) begin errors++; $display("FAIL reset_start: got %0d want 0", start_addr); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL reset_auto: got %b want 0", auto_trig); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    cycle();
    exp_addr = 8'd0;
  endtask

  // Ramp 0x700.. crosses 0x800 on strobe 257, which lands on address 0 after a wrap.
  task automatic test_normal_rising();
    mode = 2'b01; slope = 1'b0; level = 12'h800;
    cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_busy: got %b want 1", busy); end
    for (int k = 0; k < 448; k++) begin
      strobe(12'(12'h700 + k), 1'b1);
      if (k == 446) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL normal_early_ready: got %b want 0", ready); end
      end
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL normal_ready: got %b want 1", ready); end
    checks++; if (start_addr !== 8'd192) begin errors++; $display("FAIL normal_start: got %0d want 192", start_addr); end
    checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL normal_auto: got %b want 0", auto_trig); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_done_busy: got %b want 0", busy); end
    strobe(12'h8C0, 1'b0);
  endtask

  task automatic test_holdoff();
    pulse_read();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b want 1", busy); end
    for (int i = 0; i < 16; i++) strobe(12'h123, 1'b0);
    // Prefill resumes at 192, wraps through 255 -> 0 into ARMED.
    for (int i = 0; i < 66; i++) strobe(12'h100, 1'b1);
    mode = 2'b11;
    cycle();
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_stop_busy: got %b want 0", busy); end
    strobe(12'h100, 1'b0);
  endtask

  task automatic test_stop_mid_post();
    mode = 2'b01; slope = 1'b0; level = 12'h800;
    cycle();
    for (int i = 0; i < 64; i++) strobe(12'h100, 1'b1);
    trig_addr = exp_addr;
    strobe(12'h900, 1'b1);
    for (int i = 0; i < 9; i++) strobe(12'h901, 1'b1);
    exp_start = trig_addr - 8'd64;
    checks++; if (start_addr !== exp_start) begin errors++; $display("FAIL stop_start: got %0d want %0d", start_addr, exp_start); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_post_busy: got %b want 1", busy); end
    // STOP together with a strobe: the strobe must not be written.
    mode = 2'b11; sample_en = 1'b1; sample = 12'h955;
    cycle();
    sample_en = 1'b0;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stop_wr_en: got %b want 0", wr_en); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL stop_ready: got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy); end
    checks++; if (wr_addr !== exp_addr) begin errors++; $display("FAIL stop_wr_addr: got %0d want %0d", wr_addr, exp_addr); end
    checks++; if (start_addr !== exp_start) begin errors++; $display("FAIL stop_start_hold: got %0d want %0d", start_addr, exp_start); end
    cycle();
  endtask

  task automatic test_falling();
    mode = 2'b01; slope = 1'b1; level = 12'h800;
    cycle();
    // Samples equal to level never trigger.
    for (int i = 0; i < 264; i++) strobe(12'h800, 1'b1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fall_equal_ready: got %b want 0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fall_equal_busy: got %b want 1", busy); end
    strobe(12'h900, 1'b1);
    trig_addr = exp_addr;
    strobe(12'h7FF, 1'b1);
    for (int i = 0; i < 190; i++) strobe(12'h700, 1'b1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fall_early_ready: got %b want 0", ready); end
    strobe(12'h700, 1'b1);
    exp_start = trig_addr - 8'd64;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fall_ready: got %b want 1", ready); end
    checks++; if (start_addr !== exp_start) begin errors++; $display("FAIL fall_start: got %0d want %0d", start_addr, exp_start); end
    checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL fall_auto: got %b want 0", auto_trig); end
    pulse_read();
    stop_now();
    slope = 1'b0;
  endtask

  task automatic test_auto();
    mode = 2'b00; slope = 1'b0; level = 12'h800;
    cycle();
    for (int k = 1; k <= 4351; k++) begin
      if (k == 4160) trig_addr = exp_addr;
      strobe(12'h100, 1'b1);
      if (k == 4350) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL auto_early_ready: got %b want 0", ready); end
      end
    end
    exp_start = trig_addr - 8'd64;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL auto_ready: got %b want 1", ready); end
    checks++; if (auto_trig !== 1'b1) begin errors++; $display("FAIL auto_flag: got %b want 1", auto_trig); end
    checks++; if (start_addr !== exp_start) begin errors++; $display("FAIL auto_start: got %0d want %0d", start_addr, exp_start); end
    pulse_read();
    stop_now();
    // Same stimulus in NORMAL never completes a frame.
    mode = 2'b01;
    cycle();
    for (int k = 0; k < 4400; k++) strobe(12'h100, 1'b1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL normal_notrig_ready: got %b want 0", ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL normal_notrig_busy: got %b want 1", busy); end
    stop_now();
  endtask

  task automatic test_single();
    mode = 2'b10; slope = 1'b0; level = 12'h800;
    cycle();
    for (int i = 0; i < 3; i++) strobe(12'h100, 1'b0);
    pulse_arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 0; i < 64; i++) strobe(12'h100, 1'b1);
    pulse_read();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_read_ignored: got %b want 0", ready); end
    trig_addr = exp_addr;
    strobe(12'h900, 1'b1);
    for (int i = 0; i < 191; i++) strobe(12'h901, 1'b1);
    exp_start = trig_addr - 8'd64;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", ready); end
    checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL single_auto: got %b want 0", auto_trig); end
    checks++; if (start_addr !== exp_start) begin errors++; $display("FAIL single_start: got %0d want %0d", start_addr, exp_start); end
    pulse_read();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_taken: got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    for (int i = 0; i < 4; i++) strobe(12'h333, 1'b0);
    pulse_arm();
    strobe(12'h222, 1'b1);
    stop_now();
  endtask

  task automatic test_async_reset();
    mode = 2'b01; slope = 1'b0; level = 12'h800;
    cycle();
    for (int i = 0; i < 69; i++) strobe(12'h100, 1'b1);
    sample_en = 1'b1; sample = 12'h900;
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, start_addr, ready, auto_trig, busy} !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: got en=%b addr=%0d data=%h start=%0d rdy=%b auto=%b busy=%b want all 0",
               wr_en, wr_addr, wr_data, start_addr, ready, auto_trig, busy);
    end
    sample_en = 1'b0;
    cycle();
    checks++; if (busy !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL async_reset_hold: busy=%b wr_en=%b want 0 0", busy, wr_en); end
    mode = 2'b11;
    rst = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_normal_rising();
    test_holdoff();
    test_stop_mid_post();
    test_falling();
    test_auto();
    test_single();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
